// File: rtl/pc_ctrl.sv
// Fetch PC register and next-PC selection for a delayed-branch pipeline.
// Also produces redirect/flush indications and a saturating redirect counter.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       npc_op,
    input  logic             cmp_out,
    input  logic             likely,
    input  logic [31:0]      D_pc,
    input  logic [15:0]      D_imm16,
    input  logic [25:0]      D_index,
    input  logic [31:0]      D_rs,
    output logic [31:0]      F_pc,
    output logic             flush_F,
    output logic             redirect,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam logic [2:0] OP_PC4 = 3'd0;
    localparam logic [2:0] OP_BR  = 3'd1;
    localparam logic [2:0] OP_J   = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_pc4;
    logic [31:0]      w_dpc4;
    logic [31:0]      w_br_tgt;
    logic [31:0]      w_j_tgt;
    logic [31:0]      w_npc;
    logic             w_redirect;
    logic             w_flush;

    assign w_pc4    = r_pc + 32'd4;
    assign w_dpc4   = D_pc + 32'd4;
    assign w_br_tgt = w_dpc4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign w_j_tgt  = {w_dpc4[31:28], D_index, 2'b00};

    // Reserved op codes fall through to sequential fetch.
    always_comb begin
        w_npc      = w_pc4;
        w_redirect = 1'b0;
        case (npc_op)
            OP_BR: if (cmp_out) begin
                w_npc      = w_br_tgt;
                w_redirect = 1'b1;
            end
            OP_J: begin
                w_npc      = w_j_tgt;
                w_redirect = 1'b1;
            end
            OP_JR: begin
                w_npc      = D_rs;
                w_redirect = 1'b1;
            end
            default: w_npc = w_pc4;
        endcase
        if (stall)
            w_redirect = 1'b0;
    end

    // Only an untaken likely branch annuls its delay slot.
    assign w_flush = !stall && (npc_op == OP_BR) && likely && !cmp_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
        end else if (!stall) begin
            r_pc <= w_npc;
            if (w_redirect && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign F_pc        = r_pc;
    assign taken_cnt   = r_cnt;
    assign redirect    = w_redirect;
    assign flush_F     = w_flush;
    assign pc_misalign = (r_pc[1:0] != 2'b00);
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, fetch address loaded on reset.
REQ-002 Parameter: CNT_W, 16, width of the taken-redirect counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 stall  input  1  hazard stall from D stage; 1 = hold PC and counter.
REQ-006 npc_op  input  3  D-stage next-PC select: 0 PC4, 1 BRANCH, 2 J, 3 JR; 4-7 reserved.
REQ-007 cmp_out  input  1  branch condition result from the D-stage comparator.
REQ-008 likely  input  1  D-stage branch is a "likely" variant (annul delay slot if not taken).
REQ-009 D_pc  input  32  PC of the instruction currently in D.
REQ-010 D_imm16  input  16  branch offset field of the D instruction.
REQ-011 D_index  input  26  jump index field of the D instruction.
REQ-012 D_rs  input  32  forwarded rs value for JR.
REQ-013 F_pc  output  32  current fetch address (register).
REQ-014 flush_F  output  1  annul the delay-slot instruction being fetched this cycle.
REQ-015 redirect  output  1  next PC is not F_pc+4 this cycle.
REQ-016 pc_misalign  output  1  F_pc[1:0] != 2'b00.
REQ-017 taken_cnt  output  CNT_W  count of accepted redirects since reset.

Function
REQ-018 F_pc SHALL be a 32-bit register; next value NPC loaded every rising edge with reset=1 and stall=0.
REQ-019 With stall=1, F_pc and taken_cnt SHALL hold; flush_F and redirect SHALL be 0.
REQ-020 NPC for PC4 and reserved codes 4-7: F_pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 NPC for BRANCH with cmp_out=1: D_pc+4+(sign-extended D_imm16 << 2), modulo 2^32.
REQ-022 NPC for BRANCH with cmp_out=0: F_pc+4.
REQ-023 NPC for J: {D_pc+4 bits [31:28], D_index, 2'b00}; cmp_out ignored.
REQ-024 NPC for JR: D_rs unmodified, even if misaligned; cmp_out ignored.
REQ-025 redirect SHALL be 1 (combinational, stall=0) for BRANCH taken, J or JR; else 0.
REQ-026 flush_F SHALL be 1 (combinational) only when stall=0, npc_op=BRANCH, likely=1, cmp_out=0; likely SHALL be ignored for other npc_op values.
REQ-027 Delay slot: a taken branch/jump SHALL NOT flush; the instruction at F_pc continues to D.
REQ-028 taken_cnt SHALL increment by 1 on each edge where redirect=1 and reset=1; saturates at all-ones (no wrap).
REQ-029 pc_misalign SHALL be combinational from F_pc; pc_ctrl takes no other action on misalignment.
REQ-030 Latency: a redirect decided in cycle n SHALL appear on F_pc in cycle n+1; no further bubbles inserted.
REQ-031 All outputs SHALL be free of X when inputs are known; no latches.

Reset
REQ-032 On a rising edge with reset=0: F_pc <= RESET_PC, taken_cnt <= 0, regardless of stall or npc_op.
REQ-033 During reset flush_F and redirect SHALL still follow REQ-025/026 combinationally; the register load of REQ-032 has priority over NPC.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL discard the pending target; first post-reset fetch is RESET_PC.

Verification
REQ-035 reset=0 one cycle, then npc_op=0 for 3 cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; taken_cnt 0.
REQ-036 F_pc=0x3008, D_pc=0x3004, npc_op=1, cmp_out=1, D_imm16=0xFFFE -> next F_pc 0x3000, redirect=1, flush_F=0, taken_cnt+1.
REQ-037 Same with cmp_out=0, likely=1 -> flush_F=1, redirect=0, next F_pc 0x300C; with stall=1 instead -> flush_F=0, F_pc holds 0x3008.
REQ-038 D_pc=0x3004, npc_op=2, D_index=0x000_0C40 -> next F_pc 0x0000_3100; npc_op=3, D_rs=0x0000_3202 -> next F_pc 0x3202, pc_misalign=1.
REQ-039 F_pc=0xFFFF_FFFC, npc_op=0 -> next F_pc 0x0000_0000; taken_cnt preset to 0xFFFF (via 65535 redirects) plus one J -> stays 0xFFFF.
REQ-040 npc_op=3 with stall=0 and reset=0 on same edge -> F_pc 0x3000, taken_cnt 0.
